// File: rtl/lvds_pkg.sv
// Shared definitions for the 7:1 LVDS transmit path.
// Holds word geometry, the serial clock pattern, the pixel payload struct
// and the colour packing function, which is also used by receiver-side models.
package lvds_pkg;

  localparam int unsigned WORD_W        = 28;
  localparam int unsigned LANES         = 4;
  localparam int unsigned BITS_PER_LANE = 7;
  localparam int unsigned PHASE_W       = 3;
  localparam int unsigned HSYNC_BIT     = 18;
  localparam int unsigned VSYNC_BIT     = 19;
  localparam int unsigned DE_BIT        = 20;

  localparam logic [BITS_PER_LANE-1:0] CLK_PATTERN = 7'b1100011;
  localparam logic [PHASE_W-1:0]       LAST_PHASE  = 3'd6;

  typedef enum logic {
    MODE_STD     = 1'b0,
    MODE_MSB_LOW = 1'b1
  } color_mode_e;

  // 27-bit FIFO payload: sync/enable plus 24-bit colour
  typedef struct packed {
    logic       de;
    logic       vsync_n;
    logic       hsync_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Map one pixel onto the 28-bit serial word; bit 27 is always 0
  function automatic logic [WORD_W-1:0] pack_word(color_mode_e mode, pixel_t px);
    logic [WORD_W-1:0] w;
    w            = '0;
    w[HSYNC_BIT] = px.hsync_n;
    w[VSYNC_BIT] = px.vsync_n;
    w[DE_BIT]    = px.de;
    if (mode == MODE_MSB_LOW) begin
      w[5:0]   = px.r[7:2];
      w[22:21] = px.r[1:0];
      w[11:6]  = px.g[7:2];
      w[24:23] = px.g[1:0];
      w[17:12] = px.b[7:2];
      w[26:25] = px.b[1:0];
    end else begin
      w[5:0]   = px.r[5:0];
      w[22:21] = px.r[7:6];
      w[11:6]  = px.g[5:0];
      w[24:23] = px.g[7:6];
      w[17:12] = px.b[5:0];
      w[26:25] = px.b[7:6];
    end
    return w;
  endfunction

endpackage

// File: rtl/lvds_tx_fifo.sv
// Pixel FIFO for the LVDS transmitter.
// Ports: clk/reset; wr_en_i + wr_data_i push; rd_en_i pops, rd_data_o shows head;
// full_o/empty_o are decoded from the registered occupancy count.
module lvds_tx_fifo
  import lvds_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   wr_en_i,
  input  pixel_t wr_data_i,
  input  logic   rd_en_i,
  output pixel_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_c, rd_c;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_c     = wr_en_i && !full_o;
    rd_c     = rd_en_i && !empty_o;
    wr_ptr_d = wr_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_c) - CNT_W'(rd_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/lvds_transmitter.sv
// 4-lane 7:1 LVDS serializer running on the bit clock.
// Ports: clk/reset; color_mode packing select; in_valid/in_ready pixel handshake
// with in_hsync_n/in_vsync_n/in_de/in_data; serial_clk + serial_data[3:0] outputs;
// underflow_count of inserted blanking words with underflow_clear.
module lvds_transmitter
  import lvds_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             color_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_hsync_n,
  input  logic             in_vsync_n,
  input  logic             in_de,
  input  logic [23:0]      in_data,
  output logic             serial_clk,
  output logic [LANES-1:0] serial_data,
  output logic [CNT_W-1:0] underflow_count,
  input  logic             underflow_clear
);

  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic [1:0]               mode_sync_q;
  logic [WORD_W-1:0]        word_q, word_d;
  logic                     serial_clk_q, serial_clk_d;
  logic [LANES-1:0]         serial_data_q, serial_data_d;
  logic [CNT_W-1:0]         ucnt_q, ucnt_d;
  logic                     last_hs_q, last_hs_d;
  logic                     last_vs_q, last_vs_d;
  logic                     fifo_full, fifo_empty;
  logic                     load_c, pop_c, wr_en_c;
  pixel_t                   wr_px_c, head_px, src_px_c;
  logic [BITS_PER_LANE-1:0] lane_w [LANES];

  assign serial_clk      = serial_clk_q;
  assign serial_data     = serial_data_q;
  assign underflow_count = ucnt_q;

  // Ready is held low while reset is asserted
  assign in_ready = !reset && !fifo_full;
  assign wr_en_c  = in_valid && in_ready;
  assign wr_px_c  = '{de: in_de, vsync_n: in_vsync_n, hsync_n: in_hsync_n,
                      r: in_data[23:16], g: in_data[15:8], b: in_data[7:0]};

  assign load_c = (phase_q == LAST_PHASE);
  assign pop_c  = load_c && !fifo_empty;

  lvds_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_c),
    .wr_data_i (wr_px_c),
    .rd_en_i   (pop_c),
    .rd_data_o (head_px),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Lane g carries word bits [7g+6:7g], MSB first: phase k emits bit 6-k
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_w[g]        = word_d[g*BITS_PER_LANE +: BITS_PER_LANE];
    assign serial_data_d[g] = lane_w[g][LAST_PHASE - phase_d];
  end

  always_comb begin
    phase_d = load_c ? '0 : phase_q + PHASE_W'(1);

    // Empty FIFO at load time: blank word repeating the last sync levels
    src_px_c = head_px;
    if (fifo_empty) begin
      src_px_c         = '0;
      src_px_c.hsync_n = last_hs_q;
      src_px_c.vsync_n = last_vs_q;
    end

    word_d       = load_c ? pack_word(color_mode_e'(mode_sync_q[1]), src_px_c) : word_q;
    serial_clk_d = CLK_PATTERN[phase_d];
    last_hs_d    = load_c ? src_px_c.hsync_n : last_hs_q;
    last_vs_d    = load_c ? src_px_c.vsync_n : last_vs_q;

    // Clear dominates, but a coinciding underflow still counts as one
    ucnt_d = ucnt_q;
    if (load_c && fifo_empty) begin
      if (underflow_clear)  ucnt_d = CNT_W'(1);
      else if (!(&ucnt_q))  ucnt_d = ucnt_q + CNT_W'(1);
    end else if (underflow_clear) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= LAST_PHASE;
      mode_sync_q   <= '0;
      word_q        <= '0;
      serial_clk_q  <= 1'b0;
      serial_data_q <= '0;
      ucnt_q        <= '0;
      last_hs_q     <= 1'b1;
      last_vs_q     <= 1'b1;
    end else begin
      phase_q       <= phase_d;
      mode_sync_q   <= {mode_sync_q[0], color_mode};
      word_q        <= word_d;
      serial_clk_q  <= serial_clk_d;
      serial_data_q <= serial_data_d;
      ucnt_q        <= ucnt_d;
      last_hs_q     <= last_hs_d;
      last_vs_q     <= last_vs_d;
    end
  end

endmodule

// File: tb/tb_lvds_transmitter.sv
// Scoreboard bench for lvds_transmitter: a transaction-level model predicts each
// 28-bit word at every load slot; a monitor deserialises the lanes and compares.
module tb_lvds_transmitter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam logic [6:0]  PAT   = 7'b1100011;
  localparam logic [CW-1:0] UMAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          color_mode;
  logic          in_valid;
  logic          in_ready;
  logic          in_hsync_n, in_vsync_n, in_de;
  logic [23:0]   in_data;
  logic          serial_clk;
  logic [3:0]    serial_data;
  logic [CW-1:0] underflow_count;
  logic          underflow_clear;

  lvds_transmitter #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .color_mode      (color_mode),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_hsync_n      (in_hsync_n),
    .in_vsync_n      (in_vsync_n),
    .in_de           (in_de),
    .in_data         (in_data),
    .serial_clk      (serial_clk),
    .serial_data     (serial_data),
    .underflow_count (underflow_count),
    .underflow_clear (underflow_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] word;
    logic        mode;
    logic [23:0] rgb;
    logic        pix;
  } exp_t;

  exp_t          exp_q[$];
  logic [26:0]   mfifo[$];
  logic [2:0]    ph;
  logic [CW-1:0] ucnt;
  logic          last_hs, last_vs;
  bit            started;
  bit            acc_last;
  int            compared   = 0;
  int            mismatched = 0;
  logic [6:0]    rx_lane [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Colour byte -> {low6, high2} field values for a given mode
  function automatic logic [7:0] split(input logic mode, input logic [7:0] c);
    return mode ? {c[7:2], c[1:0]} : {c[5:0], c[7:6]};
  endfunction

  function automatic logic [27:0] ref_pack(input logic mode, input logic hs, input logic vs,
                                           input logic de, input logic [23:0] rgb);
    logic [27:0] w;
    logic [7:0]  sr, sg, sb;
    sr = split(mode, rgb[23:16]);
    sg = split(mode, rgb[15:8]);
    sb = split(mode, rgb[7:0]);
    w  = {1'b0, sb[1:0], sg[1:0], sr[1:0], de, vs, hs, sb[7:2], sg[7:2], sr[7:2]};
    return w;
  endfunction

  // Receiver-side recovery of the 24-bit colour from a word
  function automatic logic [23:0] ref_unpack(input logic mode, input logic [27:0] w);
    logic [7:0] r, g, b;
    if (mode) begin
      r = {w[5:0], w[22:21]};   g = {w[11:6], w[24:23]};  b = {w[17:12], w[26:25]};
    end else begin
      r = {w[22:21], w[5:0]};   g = {w[24:23], w[11:6]};  b = {w[26:25], w[17:12]};
    end
    return {r, g, b};
  endfunction

  // Model: every 7th clock is a load slot; pop if something queued earlier, else blank
  always @(posedge clk or posedge reset) begin
    int unsigned n;
    exp_t        e;
    logic [26:0] px;
    if (reset) begin
      mfifo.delete();
      exp_q.delete();
      ph       = 3'd6;
      ucnt     = '0;
      last_hs  = 1'b1;
      last_vs  = 1'b1;
      started  = 0;
      acc_last = 0;
    end else begin
      n        = mfifo.size();
      acc_last = in_valid && (n < DEPTH);
      if (ph == 3'd6) begin
        if (n != 0) begin
          px      = mfifo.pop_front();
          last_hs = px[24];
          last_vs = px[25];
          e.word  = ref_pack(color_mode, px[24], px[25], px[26], px[23:0]);
          e.mode  = color_mode;
          e.rgb   = px[23:0];
          e.pix   = 1'b1;
          if (underflow_clear) ucnt = '0;
        end else begin
          e.word = ref_pack(1'b0, last_hs, last_vs, 1'b0, 24'h0);
          e.mode = 1'b0;
          e.rgb  = 24'h0;
          e.pix  = 1'b0;
          if (underflow_clear)   ucnt = 1;
          else if (ucnt != UMAX) ucnt = ucnt + 1'b1;
        end
        exp_q.push_back(e);
        started = 1;
      end else if (underflow_clear) begin
        ucnt = '0;
      end
      if (acc_last) mfifo.push_back({in_de, in_vsync_n, in_hsync_n, in_data});
      ph = (ph == 3'd6) ? 3'd0 : ph + 3'd1;
    end
  end

  // Monitor: sample outputs mid-cycle, rebuild each word, compare with scoreboard
  always @(negedge clk) begin
    exp_t        e;
    logic [27:0] w;
    if (reset) begin
      for (int i = 0; i < 4; i++) rx_lane[i] = '0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(mfifo.size() < DEPTH));
      check("underflow_count", 32'(underflow_count), 32'(ucnt));
      if (started) begin
        check("serial_clk", 32'(serial_clk), 32'(PAT[ph]));
        for (int i = 0; i < 4; i++) rx_lane[i] = {rx_lane[i][5:0], serial_data[i]};
        if (ph == 3'd6) begin
          w = {rx_lane[3], rx_lane[2], rx_lane[1], rx_lane[0]};
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL word_underrun: got %0h expected none queued", w);
          end else begin
            e = exp_q.pop_front();
            check("word", 32'(w), 32'(e.word));
            if (e.pix) begin
              check("lane2", 32'(rx_lane[2]), 32'(e.word[20:14]));
              check("roundtrip_rgb", 32'(ref_unpack(e.mode, w)), 32'(e.rgb));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [23:0] rgb, input logic de, input logic hs, input logic vs);
    int t = 0;
    in_valid = 1'b1; in_data = rgb; in_de = de; in_hsync_n = hs; in_vsync_n = vs;
    do begin @(negedge clk); t++; end while (!acc_last && t < 200);
    check("send_accepted", 32'(acc_last), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(24'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
  endtask

  task automatic wait_ph(input logic [2:0] target);
    int t = 0;
    do begin @(negedge clk); t++; end while (ph != target && t < 20);
    if (ph != target) begin
      compared++; mismatched++;
      $display("FAIL wait_phase: got %0d expected %0d", ph, target);
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (mfifo.size() != 0 && t < 200) begin @(negedge clk); t++; end
    check("drain_empty", 32'(mfifo.size()), 32'd0);
  endtask

  task automatic set_mode(input logic m);
    drain();
    color_mode = m;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    reset = 1'b1; color_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    in_de = 1'b0; in_hsync_n = 1'b1; in_vsync_n = 1'b1; underflow_clear = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_serial_clk", 32'(serial_clk), 32'd0);
    check("rst_serial_data", 32'(serial_data), 32'd0);
    check("rst_underflow", 32'(underflow_count), 32'd0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("first_blank_count", 32'(underflow_count), 32'd1);
    repeat (34) @(negedge clk);

    // Directed pixel in both packing modes
    send(24'hA53C0F, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    set_mode(1'b1);
    send(24'hA53C0F, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // Random sparse traffic, mode 1 then mode 0
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      send_rand();
    end
    set_mode(1'b0);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      send_rand();
    end
    drain();

    // in_valid held: fill to full, then one accept per word slot
    in_valid = 1'b1; in_data = 24'($urandom); in_de = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (acc_last) in_data = 24'($urandom);
    end
    drain();

    // Saturation of the underflow counter
    t = 0;
    while (ucnt != UMAX && t < 3000) begin @(negedge clk); t++; end
    repeat (21) @(negedge clk);
    check("ucnt_saturated", 32'(underflow_count), 32'(UMAX));

    // Clear coinciding with an underflow load gives 1; clear alone gives 0
    wait_ph(3'd6);
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    check("clear_with_underflow", 32'(underflow_count), 32'd1);
    wait_ph(3'd2);
    underflow_clear = 1'b1;
    @(negedge clk);
    underflow_clear = 1'b0;
    check("clear_alone", 32'(underflow_count), 32'd0);
    repeat (14) @(negedge clk);

    // Reset in the middle of a word
    send(24'h123456, 1'b1, 1'b0, 1'b1);
    wait_ph(3'd3);
    #2 reset = 1'b1;
    #1;
    check("midword_serial_clk", 32'(serial_clk), 32'd0);
    check("midword_serial_data", 32'(serial_data), 32'd0);
    check("midword_underflow", 32'(underflow_count), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_reset_count", 32'(underflow_count), 32'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) send_rand();
    drain();
    repeat (16) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
